udp_payload_frame_buffer: RTL

- Store-and-forward frame FIFO for UDP payload.
- Sits between the UDP stack's received-payload AXI-Stream output and its transmit-payload input in the echo path.
- Releases a frame downstream only after its last byte arrives with no error.
- Replaces any errored or oversize frame with a single error beat, so the already-issued transmit UDP header is still terminated cleanly.

---
 rtl/udp_buf_pkg.sv | 25 ++
 rtl/udp_buf_ram.sv | 37 +++
 rtl/udp_payload_frame_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/udp_buf_pkg.sv
// Shared definitions for the UDP payload frame buffer: stored-word layout,
// error-beat encoding and write-FSM state encoding.
// Ports: none (package).
package udp_buf_pkg;

  // Stored word layout: {user, last, data[7:0]}
  localparam int WORD_W   = 10;
  localparam int USER_BIT = 9;
  localparam int LAST_BIT = 8;
  localparam int DATA_MSB = 7;

  typedef enum logic {
    WR_STORE = 1'b0,
    WR_DROP  = 1'b1
  } wr_state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic user, input logic last,
                                                  input logic [DATA_MSB:0] dat);
    return {user, last, dat};
  endfunction

  // Replacement for a bad frame: one zero byte flagged as last + error
  localparam logic [WORD_W-1:0] ERR_WORD = {1'b1, 1'b1, 8'h00};

endpackage

// File: rtl/udp_buf_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
// Latency: read data valid the cycle after rd_en; rd_dat holds when rd_en is low.
// Backpressure: none; the caller guarantees address safety.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_en/rd_addr read request; rd_dat read data.
module udp_buf_ram #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read register has no reset; the consumer tracks its validity separately.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_dat_q <= mem[rd_addr];
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/udp_payload_frame_buffer.sv
// Store-and-forward UDP payload frame FIFO; bad/oversize frames become one error beat.
// Latency: tlast accepted in cycle N -> first byte on m_axis in cycle N+2 (output idle).
// Backpressure: s_axis_tready drops only when no room is left for an error beat;
//   m_axis held stable under stall, one-entry skid absorbs the in-flight read.
// Ports: clk, rst (sync, active-high); s_axis_* received payload in;
//   m_axis_* transmit payload out (tuser marks the error beat).
// Option: define UDP_BUF_STATUS_EN to add good_frames/bad_frames saturating counters.
module udp_payload_frame_buffer
  import udp_buf_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
`ifdef UDP_BUF_STATUS_EN
  ,
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // ---------------- write side ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic [PTR_W-1:0]  wr_cur_q, wr_cur_d;
  logic [PTR_W-1:0]  wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  used, committed;
  logic              full, err_blocked, in_fire;
  logic              good_commit, err_commit;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WORD_W-1:0] ram_wdat;

  always_comb begin
    used        = wr_cur_q - rd_ptr_q;
    committed   = wr_commit_q - rd_ptr_q;
    full        = (used >= FULL_LVL);
    // Committed data at DEPTH-1 leaves no slot for a future error beat, so
    // stall rather than accept a beat we might be unable to terminate.
    err_blocked = (committed >= FULL_LVL);

    s_axis_tready = !rst && !err_blocked;
    in_fire       = s_axis_tvalid && s_axis_tready;

    wr_state_d  = wr_state_q;
    wr_cur_d    = wr_cur_q;
    wr_commit_d = wr_commit_q;
    good_commit = 1'b0;
    err_commit  = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = wr_cur_q[ADDR_W-1:0];
    ram_wdat    = pack_word(1'b0, 1'b0, s_axis_tdata);

    if (in_fire) begin
      unique case (wr_state_q)
        WR_STORE: begin
          if (s_axis_tlast) begin
            // A tlast arriving with no space is an overflow, same as tuser.
            if (s_axis_tuser || full) begin
              err_commit = 1'b1;
            end else begin
              good_commit = 1'b1;
            end
          end else if (full) begin
            // Oversize frame: discard what was stored and swallow the rest.
            wr_cur_d   = wr_commit_q;
            wr_state_d = WR_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_cur_d = wr_cur_q + PTR_ONE;
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            err_commit = 1'b1;
            wr_state_d = WR_STORE;
          end
        end
        default: wr_state_d = WR_STORE;
      endcase
    end

    if (good_commit) begin
      ram_we      = 1'b1;
      ram_wdat    = pack_word(1'b0, 1'b1, s_axis_tdata);
      wr_cur_d    = wr_cur_q + PTR_ONE;
      wr_commit_d = wr_cur_q + PTR_ONE;
    end

    if (err_commit) begin
      // Roll back the partial frame and put the error beat in its place.
      ram_we      = 1'b1;
      ram_waddr   = wr_commit_q[ADDR_W-1:0];
      ram_wdat    = ERR_WORD;
      wr_cur_d    = wr_commit_q + PTR_ONE;
      wr_commit_d = wr_commit_q + PTR_ONE;
    end
  end

  // ---------------- read side ----------------
  // ram_vld_q: RAM read register holds an unconsumed word.
  // skid_vld_q: older word parked while the RAM register took the next one.
  // Reads are issued from registered state only, so m_axis_tready has no
  // combinational path into the RAM.
  logic              rd_en, avail, consume;
  logic              ram_vld_q, ram_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [WORD_W-1:0] skid_dat_q, skid_dat_d;
  logic [WORD_W-1:0] ram_rdat, head;

  always_comb begin
    avail    = (rd_ptr_q != wr_commit_q);
    rd_en    = avail && !skid_vld_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    m_axis_tvalid = skid_vld_q || ram_vld_q;
    head          = skid_vld_q ? skid_dat_q : ram_rdat;
    consume       = m_axis_tvalid && m_axis_tready;

    ram_vld_d  = ram_vld_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;

    if (skid_vld_q) begin
      // No read issued while the skid is occupied; RAM word waits behind it.
      if (consume) begin
        skid_vld_d = 1'b0;
      end
    end else begin
      if (rd_en && ram_vld_q && !consume) begin
        skid_vld_d = 1'b1;
        skid_dat_d = ram_rdat;
      end
      ram_vld_d = rd_en || (ram_vld_q && !consume);
    end

    if (m_axis_tvalid) begin
      m_axis_tdata = head[DATA_MSB:0];
      m_axis_tlast = head[LAST_BIT];
      m_axis_tuser = head[USER_BIT];
    end else begin
      m_axis_tdata = '0;
      m_axis_tlast = 1'b0;
      m_axis_tuser = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q  <= WR_STORE;
      wr_cur_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_cur_q    <= wr_cur_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_vld_q   <= ram_vld_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
    end
  end

  udp_buf_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_dat  (ram_wdat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_dat  (ram_rdat)
  );

`ifdef UDP_BUF_STATUS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (good_commit && (good_cnt_q != 16'hFFFF)) begin
      good_cnt_d = good_cnt_q + 16'd1;
    end
    if (err_commit && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_frames = good_cnt_q;
  assign bad_frames  = bad_cnt_q;
`endif

endmodule
